// File: rtl/keypad_entry_scanner.sv
// keypad_entry_scanner: 4x4 keypad column scanner with debounce and 4-digit decimal entry.
// Optional `KEYPAD_BACKSPACE_EN makes 'D' a backspace key.
module keypad_entry_scanner #(
  parameter int SCAN_DIV     = 262144,
  parameter int DEBOUNCE_CNT = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  row_in,
  output logic [3:0]  col_out,
  output logic [12:0] value,
  output logic [2:0]  digit_count,
  output logic        key_valid,
  output logic [3:0]  key_code,
  output logic        entry_done,
  output logic        digit_rejected
);
  localparam int SW = $clog2(SCAN_DIV);
  localparam int DW = $clog2(DEBOUNCE_CNT + 1);
  localparam logic [63:0] KEY_MAP = 64'hDF0E_C987_B654_A321;
  typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD} state_t;
  state_t state, state_n;
  logic [SW-1:0] slot_cnt;
  logic [DW-1:0] db_cnt, db_cnt_n;
  logic [1:0] col, col_n, key_row, key_row_n, row_idx;
  logic [3:0] row_low, emit_code, code_n;
  logic [12:0] value_n;
  logic [16:0] t17;
  logic [2:0] count_n;
  logic slot_end, one_hot, emit, committed, committed_n, done_n, rej_n;
  assign slot_end  = slot_cnt == SW'(SCAN_DIV - 1);
  assign row_low   = ~row_in;
  assign one_hot   = (row_low != 4'd0) && ((row_low & (row_low - 4'd1)) == 4'd0);
  assign row_idx   = row_low[1] ? 2'd1 : row_low[2] ? 2'd2 : row_low[3] ? 2'd3 : 2'd0;
  // the column is held while debouncing, so col is the pressed key's column
  assign emit_code = KEY_MAP[{row_idx, col, 2'b00} +: 4];
  assign t17       = 17'(value) * 17'd10 + 17'(emit_code);
  assign col_out   = ~(4'b0001 << col);
  always_comb begin
    state_n   = state;
    col_n     = col;
    db_cnt_n  = db_cnt;
    key_row_n = key_row;
    emit      = 1'b0;
    if (slot_end) begin
      case (state)
        SCAN: begin
          if (one_hot) begin
            key_row_n = row_idx;
            emit      = DEBOUNCE_CNT == 1;
            state_n   = DEBOUNCE_CNT == 1 ? HELD : DEBOUNCE;
            db_cnt_n  = DEBOUNCE_CNT == 1 ? DW'(0) : DW'(1);
          end else col_n = col + 2'd1;
        end
        DEBOUNCE: begin
          if (one_hot && row_idx == key_row) begin
            emit     = db_cnt == DW'(DEBOUNCE_CNT - 1);
            state_n  = emit ? HELD : DEBOUNCE;
            db_cnt_n = emit ? DW'(0) : db_cnt + 1'b1;
          end else begin
            state_n  = SCAN;
            col_n    = col + 2'd1;
            db_cnt_n = '0;
          end
        end
        default: begin
          if (row_in == 4'hF) begin
            state_n  = db_cnt == DW'(DEBOUNCE_CNT - 1) ? SCAN : HELD;
            col_n    = state_n == SCAN ? col + 2'd1 : col;
            db_cnt_n = state_n == SCAN ? DW'(0) : db_cnt + 1'b1;
          end else db_cnt_n = '0;
        end
      endcase
    end
  end
  always_comb begin
    value_n     = value;
    count_n     = digit_count;
    committed_n = committed;
    code_n      = emit ? emit_code : key_code;
    done_n      = 1'b0;
    rej_n       = 1'b0;
    if (emit) begin
      if (emit_code <= 4'd9) begin
        if (committed) begin
          value_n     = 13'(emit_code);
          count_n     = 3'd1;
          committed_n = 1'b0;
        end else if (digit_count < 3'd4 && t17 <= 17'd8191) begin
          value_n = t17[12:0];
          count_n = digit_count + 3'd1;
        end else rej_n = 1'b1;
      end else if (emit_code == 4'hE) begin
        value_n     = '0;
        count_n     = '0;
        committed_n = 1'b0;
      end else if (emit_code == 4'hF) begin
        done_n      = 1'b1;
        committed_n = 1'b1;
      end
`ifdef KEYPAD_BACKSPACE_EN
      else if (emit_code == 4'hD) begin
        if (committed) begin
          value_n     = '0;
          count_n     = '0;
          committed_n = 1'b0;
        end else if (digit_count != 3'd0) begin
          value_n = value / 13'd10;
          count_n = digit_count - 3'd1;
        end
      end
`endif
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= SCAN;
      slot_cnt       <= '0;
      db_cnt         <= '0;
      col            <= '0;
      key_row        <= '0;
      value          <= '0;
      digit_count    <= '0;
      committed      <= 1'b0;
      key_code       <= '0;
      key_valid      <= 1'b0;
      entry_done     <= 1'b0;
      digit_rejected <= 1'b0;
    end else begin
      state          <= state_n;
      slot_cnt       <= slot_end ? '0 : slot_cnt + 1'b1;
      db_cnt         <= db_cnt_n;
      col            <= col_n;
      key_row        <= key_row_n;
      value          <= value_n;
      digit_count    <= count_n;
      committed      <= committed_n;
      key_code       <= code_n;
      key_valid      <= emit;
      entry_done     <= done_n;
      digit_rejected <= rej_n;
    end
  end
endmodule

// File: tb/tb_keypad_entry_scanner.sv
// tb_keypad_entry_scanner: scoreboard bench driving a modelled 4x4 keypad.
module tb_keypad_entry_scanner;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [3:0] row_in, col_out, key_code;
  logic [12:0] value;
  logic [2:0] digit_count;
  logic key_valid, entry_done, digit_rejected;
  logic key_down = 1'b0, multi = 1'b0;
  logic [1:0] krow = 2'd0, kcol = 2'd0;
  typedef struct {int code; int val; int cnt; int done; int rej;} exp_t;
  exp_t q[$];
  exp_t e_mon;
  int vectors = 0, miscompares = 0, kv_cnt = 0, kv_cyc = 0, cyc = 0, n0 = 0, kb = 0;
  int mv = 0, mc = 0, mcom = 0;
  int kmap[16] = '{1, 2, 3, 10, 4, 5, 6, 11, 7, 8, 9, 12, 14, 0, 15, 13};
  logic [3:0] c_snap;
  assign row_in = multi ? 4'b1010 : (key_down && !col_out[kcol]) ? ~(4'b0001 << krow) : 4'hF;
  always #5 clk = ~clk;
  keypad_entry_scanner #(.SCAN_DIV(8), .DEBOUNCE_CNT(3)) dut (
    .clk(clk), .rst_n(rst_n), .row_in(row_in), .col_out(col_out), .value(value),
    .digit_count(digit_count), .key_valid(key_valid), .key_code(key_code),
    .entry_done(entry_done), .digit_rejected(digit_rejected)
  );
  task automatic check(input string tag, input int obs, input int exp);
    vectors++;
    if (obs != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (rst_n) begin
      if (key_valid) begin
        kv_cnt++;
        kv_cyc = cyc;
        if (q.size() == 0) check("unexpected_key_valid", 1, 0);
        else begin
          e_mon = q.pop_front();
          check("key_code", int'(key_code), e_mon.code);
          check("value", int'(value), e_mon.val);
          check("digit_count", int'(digit_count), e_mon.cnt);
          check("entry_done", int'(entry_done), e_mon.done);
          check("digit_rejected", int'(digit_rejected), e_mon.rej);
        end
      end else if (entry_done || digit_rejected) check("orphan_pulse", 1, 0);
    end
  end
  task automatic push_exp(input int code);
    int done = 0, rej = 0;
    if (code <= 9) begin
      if (mcom != 0) begin
        mv = code; mc = 1; mcom = 0;
      end else if (mc < 4 && mv * 10 + code <= 8191) begin
        mv = mv * 10 + code; mc++;
      end else rej = 1;
    end else if (code == 14) begin
      mv = 0; mc = 0; mcom = 0;
    end else if (code == 15) begin
      done = 1; mcom = 1;
    end
`ifdef KEYPAD_BACKSPACE_EN
    else if (code == 13) begin
      if (mcom != 0) begin
        mv = 0; mc = 0; mcom = 0;
      end else if (mc > 0) begin
        mv = mv / 10; mc--;
      end
    end
`endif
    q.push_back(exp_t'{code, mv, mc, done, rej});
  endtask
  task automatic wait_kv(input string tag);
    int k0 = kv_cnt, hit = 0;
    for (int i = 0; i < 200 && hit == 0; i++) begin
      @(negedge clk);
      #1 hit = int'(kv_cnt != k0);
    end
    check({tag, "_seen"}, hit, 1);
  endtask
  task automatic wait_col(input logic [3:0] c);
    int hit = 0;
    for (int i = 0; i < 100 && hit == 0; i++) begin
      @(negedge clk);
      hit = int'(col_out == c);
    end
    check("col_reached", hit, 1);
  endtask
  task automatic hold_release();
    repeat (16) @(negedge clk);
    key_down = 1'b0;
    repeat (40) @(negedge clk);
  endtask
  task automatic press(input int code);
    int idx = 0;
    for (int i = 0; i < 16; i++) if (kmap[i] == code) idx = i;
    krow = 2'(idx / 4);
    kcol = 2'(idx % 4);
    push_exp(code);
    key_down = 1'b1;
    wait_kv($sformatf("key%0d", code));
    hold_release();
  endtask
  task automatic check_reset_outputs(input string tag);
    check({tag, "_col"}, int'(col_out), 14);
    check({tag, "_value"}, int'(value), 0);
    check({tag, "_count"}, int'(digit_count), 0);
    check({tag, "_key_code"}, int'(key_code), 0);
    check({tag, "_pulses"}, int'({key_valid, entry_done, digit_rejected}), 0);
  endtask
  initial begin
    #1 check_reset_outputs("rst0");
    #20;
    @(negedge clk);
    rst_n = 1'b1;
    check("scan_c0", int'(col_out), 4'b1110);
    repeat (8) @(negedge clk);
    check("scan_c1", int'(col_out), 4'b1101);
    repeat (8) @(negedge clk);
    check("scan_c2", int'(col_out), 4'b1011);
    repeat (8) @(negedge clk);
    check("scan_c3", int'(col_out), 4'b0111);
    repeat (8) @(negedge clk);
    check("scan_wrap", int'(col_out), 4'b1110);
    check("idle_no_kv", kv_cnt, 0);
    krow = 2'd1;
    kcol = 2'd2;
    key_down = 1'b1;
    push_exp(6);
    wait_col(4'b1011);
    n0 = cyc;
    wait_kv("key6");
    check("kv_latency", kv_cyc - n0, 24);
    hold_release();
    check("key6_single", kv_cnt, 1);
    check("key6_value", int'(value), 6);
    press(14);
    press(8); press(1); press(9); press(2);
    check("reject_value", int'(value), 819);
    check("reject_count", int'(digit_count), 3);
    press(15);
    check("done_value", int'(value), 819);
    press(5);
    check("after_commit_value", int'(value), 5);
    check("after_commit_count", int'(digit_count), 1);
    krow = 2'd2;
    kcol = 2'd0;
    wait_col(4'b1101);
    wait_col(4'b1110);
    kb = kv_cnt;
    key_down = 1'b1;
    repeat (8) @(negedge clk);
    key_down = 1'b0;
    repeat (8) @(negedge clk);
    key_down = 1'b1;
    repeat (3) @(negedge clk);
    key_down = 1'b0;
    repeat (5) @(negedge clk);
    check("bounce_no_kv", kv_cnt - kb, 0);
    push_exp(7);
    key_down = 1'b1;
    wait_kv("bounce7");
    hold_release();
    check("bounce_single", kv_cnt - kb, 1);
    check("bounce_value", int'(value), 57);
    kb = kv_cnt;
    multi = 1'b1;
    repeat (64) @(negedge clk);
    c_snap = col_out;
    repeat (8) @(negedge clk);
    check("multi_scan", int'(col_out), int'({c_snap[2:0], c_snap[3]}));
    multi = 1'b0;
    check("multi_no_kv", kv_cnt - kb, 0);
    press(14); press(4); press(2);
    check("val_42", int'(value), 42);
    press(14);
    check("star_value", int'(value), 0);
    check("star_count", int'(digit_count), 0);
    krow = 2'd0;
    kcol = 2'd0;
    wait_col(4'b1101);
    wait_col(4'b1110);
    key_down = 1'b1;
    repeat (12) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("rst_mid");
    mv = 0; mc = 0; mcom = 0;
    repeat (3) @(negedge clk);
    push_exp(1);
    rst_n = 1'b1;
    wait_kv("rekey1");
    hold_release();
    check("rekey_value", int'(value), 1);
    press(2); press(3); press(13);
`ifdef KEYPAD_BACKSPACE_EN
    check("bs_value", int'(value), 12);
    check("bs_count", int'(digit_count), 2);
`else
    check("d_value", int'(value), 123);
    check("d_count", int'(digit_count), 3);
`endif
    check("queue_empty", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/keypad_entry_scanner.md
Name: keypad_entry_scanner

Overview:
- Input-side companion to the four-digit seven-segment display driver.
- Scans a 4x4 matrix keypad by column multiplexing, debounces presses and reports each key once.
- Accumulates decimal digits into a 13-bit value that feeds the display `num` input directly.
- Provides clear and enter keys so a user can type a number and commit it.

Parameters:
SCAN_DIV, 262144, clocks per column slot; minimum 4; sim uses 8.
DEBOUNCE_CNT, 3, consecutive identical slot-end samples required for press and for release; minimum 1.

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
row_in  input  4  keypad rows, active-low (pulled up); row_in[r] low = key in row r, driven column
col_out  output  4  keypad column drive, active-low one-hot; col c -> bit c low
value  output  13  current entry value, 0..8191
digit_count  output  3  digits in current entry, 0..4
key_valid  output  1  one-cycle pulse per debounced press
key_code  output  4  code of last debounced key; holds between pulses
entry_done  output  1  one-cycle pulse when '#' pressed
digit_rejected  output  1  one-cycle pulse when a digit is refused

Behaviour:
- Reset values (async, immediate): col_out=4'b1110, value=0, digit_count=0, key_code=0, key_valid=0, entry_done=0, digit_rejected=0, FSM=SCAN, slot counter=0, debounce counter=0, committed flag=0. Reset mid-press aborts everything; a still-held key must re-debounce from SCAN.
- Key map (row,col) -> code:
  - row0: 1,2,3,A
  - row1: 4,5,6,B
  - row2: 7,8,9,C
  - row3: E('*'),0,F('#'),D
- Slot counter counts 0..SCAN_DIV-1; the "slot end" is count SCAN_DIV-1, where row_in is sampled. A valid sample has exactly one row low; zero or multiple rows low = no key.
- SCAN: at slot end, valid sample -> latch (row,col), debounce counter=1 (or emit if DEBOUNCE_CNT=1), go DEBOUNCE, column stays. Otherwise advance column 0->1->2->3->0.
- DEBOUNCE: column held. Each slot end:
  - Same valid (row) -> counter++. On reaching DEBOUNCE_CNT: key_valid=1 for the next single cycle, key_code updated, action applied on the same edge, go HELD.
  - Mismatch or no key -> back to SCAN, advance column.
- HELD: column held. Each slot end:
  - All rows high -> release counter++.
  - Any row low -> release counter=0.
  - Release counter reaching DEBOUNCE_CNT -> SCAN, advance column.
  - No auto-repeat. A second key pressed while one is held is ignored.
- Actions (registered, visible in the key_valid cycle):
  - Digit d:
    - If committed: value=d, count=1, committed=0.
    - Otherwise compute t=value*10+d in 17 bits. If digit_count<4 and t<=8191: value=t, count++. Else no change and digit_rejected pulses.
  - '*': value=0, count=0, committed=0.
  - '#': entry_done pulses; value held; committed=1. Pulses even with count=0.
  - A, B, C: reported only. D: see optional feature.
- Outputs key_valid, entry_done and digit_rejected never stay high for more than one cycle.

Optional Feature:
KEYPAD_BACKSPACE_EN
- Defined:
  - 'D' with count>0 and not committed: value=value/10, count--.
  - 'D' with count=0: no change, no digit_rejected.
  - 'D' when committed: clears value to 0, count=0, committed=0.
- Undefined: 'D' is reported on key_code/key_valid only; value is untouched.

Test Plan (SCAN_DIV=8, DEBOUNCE_CNT=3):
- Reset, no keys -> col_out cycles 1110,1101,1011,0111 every 8 clks; value=0; no pulses.
- Hold row1 low while col2 driven, keep pressed 40 clks, release -> exactly one key_valid, key_code=6, value=6, count=1. key_valid lands on the cycle after the third matching slot-end sample.
- Keys 8,1,9,2 then '#' -> value=8192 rejected at 4th digit (digit_rejected=1, value=819, count=3). Then '#' -> entry_done=1, value=819. Then '5' -> value=5, count=1.
- Press '7' bouncing (row toggles within first 2 slots) -> no key_valid until 3 stable samples; single pulse overall.
- Rows 0 and 2 low simultaneously -> treated as no key, scanning continues. Press '*' after value=42 -> value=0, count=0.
- Assert rst_n=0 mid-DEBOUNCE -> outputs at reset values immediately; with KEYPAD_BACKSPACE_EN, sequence 1,2,3,D -> value=12, count=2.
